// File: rtl/reg_file_wb_sched_if.sv
// Bus bundle between decode, the two result producers and the reg_file write-back
// scheduler. The master drives the requests and the slave (scheduler) drives the responses.
interface reg_file_wb_sched_if #(
  parameter int AW = 5,
  parameter int DW = 32
);
  // Decode issue / hazard check
  logic          iss_valid;
  logic [AW-1:0] iss_rd;
  logic [AW-1:0] PR1;
  logic [AW-1:0] PR2;
  logic          stall;

  // Producer A: in-order pipeline WB stage
  logic          a_valid;
  logic          a_ready;
  logic [AW-1:0] a_wr;
  logic [DW-1:0] a_wd;

  // Producer B: multi-cycle unit
  logic          b_valid;
  logic          b_ready;
  logic [AW-1:0] b_wr;
  logic [DW-1:0] b_wd;

  // reg_file write port
  logic          write;
  logic [AW-1:0] WR;
  logic [DW-1:0] WD;

  modport master (
    output iss_valid, iss_rd, PR1, PR2,
    output a_valid, a_wr, a_wd,
    output b_valid, b_wr, b_wd,
    input  stall, a_ready, b_ready,
    input  write, WR, WD
  );

  modport slave (
    input  iss_valid, iss_rd, PR1, PR2,
    input  a_valid, a_wr, a_wd,
    input  b_valid, b_wr, b_wd,
    output stall, a_ready, b_ready,
    output write, WR, WD
  );
endinterface

// File: rtl/reg_file_wb_sched.sv
// Write-back scheduler for reg_file. It shares one write port between the WB stage (A)
// and the multi-cycle unit (B), and it keeps a pending-result scoreboard that stalls decode.
module reg_file_wb_sched #(
  parameter int AW      = 5,
  parameter int DW      = 32,
  parameter int NREG    = 2 ** AW,
  parameter int MAXWAIT = 3
) (
  input logic               clk,
  input logic               reset,
  reg_file_wb_sched_if.slave bus
);

  localparam int            SW         = $clog2(MAXWAIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(MAXWAIT);

  logic [SW-1:0]   starve_cnt;
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_next;
  logic            b_pri;
  logic            a_grant;
  logic            b_grant;
  logic            a_xfer;
  logic            b_xfer;
  logic            iss_accept;

  // A normally wins. B takes the port once it has been refused MAXWAIT cycles in a row.
  assign b_pri = (starve_cnt == STARVE_MAX);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    a_grant = 1'b0;
    b_grant = 1'b0;
    if (reset) begin
      if (b_pri && bus.b_valid) begin
        b_grant = 1'b1;
      end else if (bus.a_valid) begin
        a_grant = 1'b1;
      end else if (bus.b_valid) begin
        b_grant = 1'b1;
      end
    end
  end

  assign bus.a_ready = a_grant;
  assign bus.b_ready = b_grant;
  assign a_xfer      = bus.a_valid && a_grant;
  assign b_xfer      = bus.b_valid && b_grant;

  // Hazard check reads only the registered scoreboard. A result that is being
  // strobed this cycle still counts as pending, because there is no bypass.
  assign bus.stall  = reset && bus.iss_valid &&
                      (busy[bus.PR1] || busy[bus.PR2] || busy[bus.iss_rd]);
  assign iss_accept = bus.iss_valid && !bus.stall;

  // The clear is applied before the set, so a new issue to the register that
  // is retiring on the same edge leaves that register pending.
  always_comb begin
    busy_next = busy;
    if (bus.write) begin
      busy_next[bus.WR] = 1'b0;
    end
    if (iss_accept) begin
      busy_next[bus.iss_rd] = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the values from before the edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.write  <= 1'b0;
      bus.WR     <= '0;
      bus.WD     <= '0;
      // NOTE: the scoreboard is a flop vector, not RAM, and it must be reset.
      // A stale pending bit would deadlock decode.
      busy       <= '0;
      starve_cnt <= '0;
    end else begin
      bus.write <= a_xfer || b_xfer;
      if (a_xfer) begin
        bus.WR <= bus.a_wr;
        bus.WD <= bus.a_wd;
      end else if (b_xfer) begin
        bus.WR <= bus.b_wr;
        bus.WD <= bus.b_wd;
      end

      busy <= busy_next;

      if (!bus.b_valid || b_xfer) begin
        starve_cnt <= '0;
      end else if (starve_cnt != STARVE_MAX) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

  a_one_grant : assert property (@(posedge clk) disable iff (!reset)
    !(bus.a_ready && bus.b_ready));

  a_ready_needs_valid : assert property (@(posedge clk) disable iff (!reset)
    (!bus.a_ready || bus.a_valid) && (!bus.b_ready || bus.b_valid));

endmodule

// File: tb/tb_reg_file_wb_sched.sv
// Directed bench for reg_file_wb_sched. It covers reset, single writes, RAW stall timing,
// starvation arbitration, set-wins scoreboard behaviour and dropping of an in-flight result.
module tb_reg_file_wb_sched;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  reg_file_wb_sched_if #(.AW(5), .DW(32)) bus ();

  reg_file_wb_sched #(.AW(5), .DW(32), .NREG(32), .MAXWAIT(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset         = 1'b0;
    bus.iss_valid = 1'b0;
    bus.iss_rd    = '0;
    bus.PR1       = '0;
    bus.PR2       = '0;
    bus.b_valid   = 1'b0;
    bus.b_wr      = '0;
    bus.b_wd      = '0;
    bus.a_valid   = 1'b1;
    bus.a_wr      = 5'd4;
    bus.a_wd      = 32'd31;
    #1;
    vectors++;
    if (bus.a_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_a_ready: got %b want 0", bus.a_ready);
    end
    step();
    step();
    vectors++;
    if (bus.write !== 1'b0 || bus.WR !== 5'd0 || bus.WD !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_port: got write=%b WR=%0d WD=%0d want 0/0/0", bus.write, bus.WR, bus.WD);
    end
    bus.iss_valid = 1'b1;
    #1;
    vectors++;
    if (bus.stall !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_stall: got %b want 0", bus.stall);
    end
    bus.iss_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    vectors++;
    if (bus.a_ready !== 1'b1 || bus.b_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL release_ready: got a=%b b=%b want a=1 b=0", bus.a_ready, bus.b_ready);
    end
  endtask

  // A is still valid from the reset test, so the first edge after release accepts it.
  task automatic test_a_only();
    step();
    vectors++;
    if (bus.write !== 1'b1 || bus.WR !== 5'd4 || bus.WD !== 32'd31) begin
      miscompares++;
      $display("FAIL a_strobe: got write=%b WR=%0d WD=%0d want 1/4/31", bus.write, bus.WR, bus.WD);
    end
    bus.a_valid = 1'b0;
    step();
    vectors++;
    if (bus.write !== 1'b0 || bus.WR !== 5'd4 || bus.WD !== 32'd31) begin
      miscompares++;
      $display("FAIL a_one_shot: got write=%b WR=%0d WD=%0d want 0/4/31", bus.write, bus.WR, bus.WD);
    end
  endtask

  task automatic test_raw_stall();
    bus.iss_valid = 1'b1;
    bus.iss_rd    = 5'd6;
    bus.PR1       = 5'd0;
    bus.PR2       = 5'd0;
    #1;
    vectors++;
    if (bus.stall !== 1'b0) begin
      miscompares++;
      $display("FAIL raw_issue: got stall=%b want 0", bus.stall);
    end
    step();
    bus.iss_rd  = 5'd7;
    bus.PR1     = 5'd6;
    bus.a_valid = 1'b1;
    bus.a_wr    = 5'd6;
    bus.a_wd    = 32'h66;
    #1;
    vectors++;
    if (bus.stall !== 1'b1 || bus.a_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL raw_hazard: got stall=%b a_ready=%b want 1/1", bus.stall, bus.a_ready);
    end
    step();
    bus.a_valid = 1'b0;
    vectors++;
    if (bus.write !== 1'b1 || bus.WR !== 5'd6 || bus.stall !== 1'b1) begin
      miscompares++;
      $display("FAIL raw_strobe: got write=%b WR=%0d stall=%b want 1/6/1", bus.write, bus.WR, bus.stall);
    end
    step();
    vectors++;
    if (bus.stall !== 1'b0 || dut.busy[6] !== 1'b0) begin
      miscompares++;
      $display("FAIL raw_release: got stall=%b busy6=%b want 0/0", bus.stall, dut.busy[6]);
    end
    bus.iss_valid = 1'b0;
  endtask

  // Both producers stay valid. With MAXWAIT=3 the grants are A,A,A,B and then repeat.
  task automatic test_arbitration();
    logic exp_b;
    bus.a_valid = 1'b1;
    bus.a_wr    = 5'd1;
    bus.a_wd    = 32'd100;
    bus.b_valid = 1'b1;
    bus.b_wr    = 5'd2;
    bus.b_wd    = 32'd200;
    for (int i = 0; i < 8; i++) begin
      exp_b = ((i % 4) == 3);
      #1;
      vectors++;
      if (bus.a_ready !== !exp_b || bus.b_ready !== exp_b) begin
        miscompares++;
        $display("FAIL arb_grant[%0d]: got a=%b b=%b want a=%b b=%b", i, bus.a_ready, bus.b_ready, !exp_b, exp_b);
      end
      step();
      vectors++;
      if (bus.write !== 1'b1 || bus.WR !== (exp_b ? 5'd2 : 5'd1) ||
          bus.WD !== (exp_b ? 32'd200 : 32'd100)) begin
        miscompares++;
        $display("FAIL arb_strobe[%0d]: got write=%b WR=%0d WD=%0d want 1/%0d/%0d", i, bus.write, bus.WR, bus.WD,
                 exp_b ? 2 : 1, exp_b ? 200 : 100);
      end
    end
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    step();
    vectors++;
    if (bus.write !== 1'b0) begin
      miscompares++;
      $display("FAIL arb_idle: got write=%b want 0", bus.write);
    end
  endtask

  task automatic test_set_wins();
    bus.a_valid = 1'b1;
    bus.a_wr    = 5'd10;
    bus.a_wd    = 32'hAA;
    step();
    bus.a_valid   = 1'b0;
    bus.iss_valid = 1'b1;
    bus.iss_rd    = 5'd10;
    bus.PR1       = 5'd0;
    bus.PR2       = 5'd0;
    #1;
    vectors++;
    if (bus.write !== 1'b1 || bus.WR !== 5'd10 || bus.stall !== 1'b0) begin
      miscompares++;
      $display("FAIL setwin_setup: got write=%b WR=%0d stall=%b want 1/10/0", bus.write, bus.WR, bus.stall);
    end
    step();
    bus.iss_rd = 5'd11;
    bus.PR2    = 5'd10;
    #1;
    vectors++;
    if (dut.busy[10] !== 1'b1 || bus.stall !== 1'b1) begin
      miscompares++;
      $display("FAIL setwin_busy: got busy10=%b stall=%b want 1/1", dut.busy[10], bus.stall);
    end
    bus.iss_valid = 1'b0;
    #1;
    vectors++;
    if (bus.stall !== 1'b0) begin
      miscompares++;
      $display("FAIL setwin_no_issue: got stall=%b want 0", bus.stall);
    end
  endtask

  task automatic test_reset_drop();
    bus.a_valid   = 1'b1;
    bus.a_wr      = 5'd13;
    bus.a_wd      = 32'd5;
    bus.b_valid   = 1'b1;
    bus.b_wr      = 5'd3;
    bus.b_wd      = 32'd9;
    bus.iss_valid = 1'b1;
    bus.iss_rd    = 5'd20;
    bus.PR1       = 5'd0;
    bus.PR2       = 5'd0;
    step();
    bus.iss_valid = 1'b0;
    bus.a_wr      = 5'd12;
    bus.a_wd      = 32'd20;
    #1;
    vectors++;
    if (dut.starve_cnt !== 2'd1 || dut.busy[20] !== 1'b1 || bus.a_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL drop_setup: got starve=%0d busy20=%b a_ready=%b want 1/1/1", dut.starve_cnt, dut.busy[20],
               bus.a_ready);
    end
    #2;
    reset = 1'b0;
    #1;
    vectors++;
    if (bus.a_ready !== 1'b0 || bus.b_ready !== 1'b0 || bus.write !== 1'b0) begin
      miscompares++;
      $display("FAIL drop_async: got a=%b b=%b write=%b want 0/0/0", bus.a_ready, bus.b_ready, bus.write);
    end
    step();
    @(negedge clk);
    reset       = 1'b1;
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    step();
    vectors++;
    if (bus.write !== 1'b0 || bus.WR !== 5'd0 || bus.WD !== 32'd0) begin
      miscompares++;
      $display("FAIL drop_port: got write=%b WR=%0d WD=%0d want 0/0/0", bus.write, bus.WR, bus.WD);
    end
    vectors++;
    if (dut.busy !== 32'd0 || dut.starve_cnt !== 2'd0) begin
      miscompares++;
      $display("FAIL drop_state: got busy=%h starve=%0d want 0/0", dut.busy, dut.starve_cnt);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_a_only();
    test_raw_stall();
    test_arbitration();
    test_set_wins();
    test_reset_drop();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
